// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Imported by mc_decode and mc_controller.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALU   = 2'b00;
   localparam logic [1:0] RES_MEM   = 2'b01;
   localparam logic [1:0] RES_PC4   = 2'b10;
   localparam logic [1:0] RES_UPPER = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      CL_COMMIT,
      CL_LOAD,
      CL_STORE,
      CL_ILLEGAL
   } iclass_t;

   typedef struct packed {
      logic [1:0] imm_sgn;
      logic [3:0] alu_main;
      logic       alu_sgn;
      logic [1:0] result_sgn;
      logic       pc_sgn;
      logic       jalr;
      logic       regwr;
   } ctrl_t;

   // alt selects SUB over ADD and SRA over SRL; callers decide when it applies.
   function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: ir + ALU zero flag -> control word and
// instruction class. Holds no state; sequencing lives in mc_controller.
module mc_decode
   import mc_pkg::*;
(
   input  logic [31:0] ir,
   input  logic        zero,
   output ctrl_t       ctrl,
   output iclass_t     iclass
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       rd_nz;
   logic       unused_ir_bits;

   assign opcode         = ir[6:0];
   assign funct3         = ir[14:12];
   assign f7b5           = ir[30];
   assign rd_nz          = |ir[11:7];
   assign unused_ir_bits = ^{ir[31], ir[29:15]};

   // NOTE: every output gets a default before the case so no path leaves a
   // latch behind.
   always_comb begin
      ctrl            = '0;
      ctrl.imm_sgn    = IMM_I;
      ctrl.alu_main   = ALU_ADD;
      ctrl.result_sgn = RES_ALU;
      iclass          = CL_COMMIT;
      case (opcode)
         OP_R: begin
            ctrl.alu_main = alu_op(funct3, f7b5);
            ctrl.regwr    = rd_nz;
         end
         OP_IMM: begin
            // funct7[5] only distinguishes srai from srli; addi ignores it
            ctrl.alu_main = alu_op(funct3, (funct3 == 3'b101) && f7b5);
            ctrl.alu_sgn  = 1'b1;
            ctrl.regwr    = rd_nz;
         end
         OP_LUI, OP_AUIPC: begin
            ctrl.result_sgn = RES_UPPER;
            ctrl.regwr      = 1'b1;
         end
         OP_JAL: begin
            ctrl.imm_sgn    = IMM_J;
            ctrl.pc_sgn     = 1'b1;
            ctrl.result_sgn = RES_PC4;
            ctrl.regwr      = 1'b1;
         end
         OP_JALR: begin
            ctrl.alu_sgn    = 1'b1;
            ctrl.jalr       = 1'b1;
            ctrl.result_sgn = RES_PC4;
            ctrl.regwr      = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.imm_sgn = IMM_B;
            case (funct3[2:1])
               2'b10:   ctrl.alu_main = ALU_SLT;
               2'b11:   ctrl.alu_main = ALU_SLTU;
               default: ctrl.alu_main = ALU_SUB;
            endcase
            // beq/bne take on zero/!zero; the set-less-than forms invert that
            ctrl.pc_sgn = funct3[2] ? ~(zero ^ funct3[0]) : (zero ^ funct3[0]);
         end
         OP_LOAD: begin
            ctrl.alu_sgn    = 1'b1;
            ctrl.result_sgn = RES_MEM;
            ctrl.regwr      = rd_nz;
            iclass          = CL_LOAD;
         end
         OP_STORE: begin
            ctrl.imm_sgn = IMM_S;
            ctrl.alu_sgn = 1'b1;
            iclass       = CL_STORE;
         end
         default: iclass = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle sequencer driving the RV32I datapath through req/ack memories.
// Optional MC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module mc_controller
   import mc_pkg::*;
#(
   parameter int RESET_WAIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ir,
   output logic [31:0] mdr,
   input  logic        zero,
   output logic        regwr_sgn,
   output logic [1:0]  imm_sgn,
   output logic [3:0]  alu_main,
   output logic        alu_sgn,
   output logic        memwr_sgn,
   output logic [1:0]  result_sgn,
   output logic        pc_sgn,
   output logic        jalr,
   output logic        pc_en,
   output logic        illegal
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam int CW = (RESET_WAIT < 1) ? 1 : $clog2(RESET_WAIT + 1);

   state_t  state, state_d;
   ctrl_t   ctrl;
   iclass_t iclass;
   logic [CW-1:0] wait_cnt;
   logic          wait_done;

   mc_decode u_decode (
      .ir     (ir),
      .zero   (zero),
      .ctrl   (ctrl),
      .iclass (iclass)
   );

   assign wait_done = (wait_cnt == CW'(RESET_WAIT));

   // Datapath selects follow ir directly so they hold steady through MEM and WB.
   assign imm_sgn    = ctrl.imm_sgn;
   assign alu_main   = ctrl.alu_main;
   assign alu_sgn    = ctrl.alu_sgn;
   assign result_sgn = ctrl.result_sgn;
   assign pc_sgn     = ctrl.pc_sgn;
   assign jalr       = ctrl.jalr;

   always_comb begin
      state_d   = state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      memwr_sgn = 1'b0;
      regwr_sgn = 1'b0;
      pc_en     = 1'b0;
      case (state)
         ST_IDLE:  if (wait_done) state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (iclass)
               CL_COMMIT: begin
                  regwr_sgn = ctrl.regwr;
                  pc_en     = 1'b1;
                  state_d   = ST_FETCH;
               end
               CL_LOAD, CL_STORE: state_d = ST_MEM;
               default:           state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = (iclass == CL_STORE);
            memwr_sgn = (iclass == CL_STORE);
            if (dmem_ack) begin
               pc_en   = (iclass == CL_STORE);
               state_d = (iclass == CL_STORE) ? ST_FETCH : ST_WB;
            end
         end
         ST_WB: begin
            regwr_sgn = ctrl.regwr;
            pc_en     = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_TRAP:  state_d = ST_TRAP;
         default:  state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         ir       <= NOP_INSTR;
         mdr      <= '0;
         illegal  <= 1'b0;
      end else begin
         state <= state_d;
         if (state == ST_IDLE && !wait_done) wait_cnt <= wait_cnt + 1'b1;
         if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
         if (state == ST_MEM && dmem_ack && iclass == CL_LOAD) mdr <= dmem_rdata;
         if (state == ST_EXEC && iclass == CL_ILLEGAL) illegal <= 1'b1;
      end
   end

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (pc_en) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (RESET_WAIT=2).
// Hand-encoded RV32I instructions with hand-computed control expectations.
module tb_mc_controller;
   logic        clk;
   logic        rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] ir, mdr;
   logic        zero;
   logic        regwr_sgn, alu_sgn, memwr_sgn, pc_sgn, jalr, pc_en, illegal;
   logic [1:0]  imm_sgn, result_sgn;
   logic [3:0]  alu_main;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int total = 0;
   int bad   = 0;

   mc_controller #(.RESET_WAIT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .ir         (ir),
      .mdr        (mdr),
      .zero       (zero),
      .regwr_sgn  (regwr_sgn),
      .imm_sgn    (imm_sgn),
      .alu_main   (alu_main),
      .alu_sgn    (alu_sgn),
      .memwr_sgn  (memwr_sgn),
      .result_sgn (result_sgn),
      .pc_sgn     (pc_sgn),
      .jalr       (jalr),
      .pc_en      (pc_en),
      .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered one ns after the edge that put the DUT in FETCH; returns likewise in EXEC.
   task automatic fetch(input logic [31:0] instr, input int waits);
      for (int i = 0; i < waits; i++) begin
         #1 check("fetch_hold", 32'(imem_req), 32'd1);
         tick();
      end
      imem_ack   = 1'b1;
      imem_rdata = instr;
      #1 check("fetch_req", 32'(imem_req), 32'd1);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   typedef struct {
      logic [31:0] instr;
      int alu, asgn, imm, res, pcs, jr, rw;
   } vec_t;

   vec_t vecs[8];
   int   pc_pulses, rw_pulses;

   initial begin
      // fields: instr, alu_main, alu_sgn, imm_sgn, result_sgn, pc_sgn, jalr, regwr (-1 = don't care)
      vecs[0] = '{32'h00500093, 0, 1, 0, 0, 0, 0, 1};   // addi x1,x0,5
      vecs[1] = '{32'h402081B3, 1, 0, -1, 0, 0, 0, 1};  // sub x3,x1,x2
      vecs[2] = '{32'h4030D213, 7, 1, 0, 0, 0, 0, 1};   // srai x4,x1,3
      vecs[3] = '{32'h123452B7, -1, -1, -1, 3, 0, 0, 1}; // lui x5,0x12345
      vecs[4] = '{32'h010000EF, -1, -1, 3, 2, 1, 0, 1}; // jal x1,16
      vecs[5] = '{32'h000100E7, 0, 1, 0, 2, -1, 1, 1};  // jalr x1,0(x2)
      vecs[6] = '{32'h0020C463, 3, -1, 2, -1, 1, 0, 0}; // blt, zero=0 -> taken
      vecs[7] = '{32'h0020F463, 4, -1, 2, -1, 0, 0, 0}; // bgeu, zero=0 -> not taken

      rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      dmem_ack = 1'b0; dmem_rdata = '0; zero = 1'b0;

      // reset state
      tick(); tick();
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_regwr",    32'(regwr_sgn), 32'd0);
      check("rst_pc_en",    32'(pc_en), 32'd0);
      check("rst_memwr",    32'(memwr_sgn), 32'd0);
      check("rst_ir",       ir, 32'h00000013);
      check("rst_mdr",      mdr, 32'h0);
      check("rst_illegal",  32'(illegal), 32'd0);

      // release: two counting IDLE edges, FETCH after the third
      rst = 1'b1;
      tick(); check("idle_1", 32'(imem_req), 32'd0);
      tick(); check("idle_2", 32'(imem_req), 32'd0);
      tick(); check("fetch_start", 32'(imem_req), 32'd1);

      // addi with zero-wait ack; stray dmem_ack in EXEC must be ignored
      fetch(32'h00500093, 0);
      dmem_ack = 1'b1;
      #1;
      check("addi_ir",     ir, 32'h00500093);
      check("addi_alusgn", 32'(alu_sgn), 32'd1);
      check("addi_alu",    32'(alu_main), 32'd0);
      check("addi_regwr",  32'(regwr_sgn), 32'd1);
      check("addi_pc_en",  32'(pc_en), 32'd1);
      tick();
      dmem_ack = 1'b0;
      #1;
      check("addi_next_fetch", 32'(imem_req), 32'd1);
      check("addi_no_dreq",    32'(dmem_req), 32'd0);
      check("addi_pc_en_off",  32'(pc_en), 32'd0);

      // decode table
      foreach (vecs[i]) begin
         fetch(vecs[i].instr, i % 2);
         zero = 1'b0;
         #1;
         if (vecs[i].alu  >= 0) check("vec_alu",   32'(alu_main), 32'(vecs[i].alu));
         if (vecs[i].asgn >= 0) check("vec_alusgn", 32'(alu_sgn), 32'(vecs[i].asgn));
         if (vecs[i].imm  >= 0) check("vec_imm",   32'(imm_sgn), 32'(vecs[i].imm));
         if (vecs[i].res  >= 0) check("vec_res",   32'(result_sgn), 32'(vecs[i].res));
         if (vecs[i].pcs  >= 0) check("vec_pcsgn", 32'(pc_sgn), 32'(vecs[i].pcs));
         check("vec_jalr",  32'(jalr), 32'(vecs[i].jr));
         check("vec_regwr", 32'(regwr_sgn), 32'(vecs[i].rw));
         check("vec_pc_en", 32'(pc_en), 32'd1);
         tick();
      end

      // lw x2,0(x1): ack on the 4th MEM cycle
      fetch(32'h0000A103, 0);
      #1;
      check("lw_alusgn", 32'(alu_sgn), 32'd1);
      check("lw_imm",    32'(imm_sgn), 32'd0);
      check("lw_pc_en",  32'(pc_en), 32'd0);
      check("lw_regwr",  32'(regwr_sgn), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            dmem_ack   = 1'b1;
            dmem_rdata = 32'hDEADBEEF;
         end
         #1;
         check("lw_req",     32'(dmem_req), 32'd1);
         check("lw_we",      32'(dmem_we), 32'd0);
         check("lw_mem_pce", 32'(pc_en), 32'd0);
         tick();
      end
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      check("lw_req_drop", 32'(dmem_req), 32'd0);
      check("lw_mdr",      mdr, 32'hDEADBEEF);
      check("wb_res",      32'(result_sgn), 32'd1);
      check("wb_regwr",    32'(regwr_sgn), 32'd1);
      check("wb_pc_en",    32'(pc_en), 32'd1);
      check("wb_alusgn",   32'(alu_sgn), 32'd1);
      tick();
      check("wb_next_fetch", 32'(imem_req), 32'd1);

      // sw x2,4(x1): ack on the 3rd MEM cycle
      fetch(32'h0020A223, 0);
      #1;
      check("sw_imm", 32'(imm_sgn), 32'd1);
      pc_pulses = int'(pc_en);
      rw_pulses = int'(regwr_sgn);
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) dmem_ack = 1'b1;
         #1;
         check("sw_memwr", 32'(memwr_sgn), 32'd1);
         check("sw_we",    32'(dmem_we), 32'd1);
         check("sw_pc_en", 32'(pc_en), (i == 2) ? 32'd1 : 32'd0);
         pc_pulses += int'(pc_en);
         rw_pulses += int'(regwr_sgn);
         tick();
      end
      dmem_ack = 1'b0;
      #1;
      rw_pulses += int'(regwr_sgn);
      check("sw_next_fetch", 32'(imem_req), 32'd1);
      check("sw_pc_pulses",  32'(pc_pulses), 32'd1);
      check("sw_rw_pulses",  32'(rw_pulses), 32'd0);

      // bne x1,x2,8 under both zero values
      fetch(32'h00209463, 0);
      zero = 1'b0;
      #1;
      check("bne_taken", 32'(pc_sgn), 32'd1);
      check("bne_alu",   32'(alu_main), 32'd1);
      check("bne_imm",   32'(imm_sgn), 32'd2);
      check("bne_pc_en", 32'(pc_en), 32'd1);
      check("bne_regwr", 32'(regwr_sgn), 32'd0);
      zero = 1'b1;
      #1;
      check("bne_not_taken", 32'(pc_sgn), 32'd0);
      tick();
      zero = 1'b0;

      // illegal opcode -> sticky trap, fetch stops
      fetch(32'h0000007F, 0);
      #1;
      check("ill_pc_en", 32'(pc_en), 32'd0);
      check("ill_regwr", 32'(regwr_sgn), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1;
         #1;
         check("trap_illegal", 32'(illegal), 32'd1);
         check("trap_no_req",  32'(imem_req), 32'd0);
         check("trap_pc_en",   32'(pc_en), 32'd0);
         tick();
      end
      imem_ack = 1'b0;

      rst = 1'b0;
      #1;
      check("trap_rst_illegal", 32'(illegal), 32'd0);
      tick();
      rst = 1'b1;
      tick(); tick(); tick();
      check("refetch", 32'(imem_req), 32'd1);

      // reset mid-MEM drops dmem_req immediately
      fetch(32'h0000A103, 0);
      tick();
      check("mid_mem_req", 32'(dmem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_dreq", 32'(dmem_req), 32'd0);
      check("mid_rst_ir",   ir, 32'h00000013);
      check("mid_rst_ill",  32'(illegal), 32'd0);
      tick();
      rst = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle sequencer that drives the RV32I datapath control inputs.
- Turns the single-cycle datapath into a multi-cycle core that tolerates variable-latency instruction and data memories via req/ack handshakes.
- Holds the instruction register (IR) and memory data register (MDR).
- Asserts pc_en and regwr_sgn only in a commit cycle; the PC register gains an enable driven by pc_en.

Parameters:
- RESET_WAIT, 0, cycles spent in IDLE after reset release before the first fetch (0 = fetch on the first edge).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  instruction fetch request
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- dmem_req  output  1  data access request
- dmem_we  output  1  data access is a write
- dmem_ack  input  1  data access complete; dmem_rdata valid on reads
- dmem_rdata  input  32  load data
- ir  output  32  latched instruction, drives datapath instr
- mdr  output  32  latched load data, drives datapath read_data
- zero  input  1  ALU zero flag from datapath
- regwr_sgn  output  1  register-file write enable
- imm_sgn  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- alu_main  output  4  ALU operation
- alu_sgn  output  1  ALU B operand: 0 rs2, 1 immediate
- memwr_sgn  output  1  data-memory write strobe
- result_sgn  output  2  writeback source: 00 ALU, 01 mem, 10 pc+4, 11 lui/auipc
- pc_sgn  output  1  next-PC select: 0 pc+4, 1 pc+imm
- jalr  output  1  next PC from ALU result
- pc_en  output  1  PC register load enable
- illegal  output  1  sticky illegal-opcode flag

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, WB, TRAP.
- rst low, asynchronously: state=IDLE, ir=32'h00000013 (NOP), mdr=0, illegal=0. All req, enable and strobe outputs are 0.
- IDLE: counts RESET_WAIT cycles, then goes to FETCH.
- FETCH:
  - imem_req=1 and is held until imem_ack=1.
  - On ack: ir<=imem_rdata, go to EXEC. An ack in the same cycle as the req is legal (zero wait).
- EXEC: decodes ir[6:0] and drives the combinational controls.
  - R 0110011 / I-ALU 0010011: regwr (rd!=0), pc_en, go to FETCH.
  - lui 0110111 / auipc 0010111: result_sgn=11, regwr, pc_en, go to FETCH.
  - jal 1101111: imm_sgn=11, pc_sgn=1, result_sgn=10, regwr, pc_en, go to FETCH.
  - jalr 1100111: alu ADD with imm, jalr=1, result_sgn=10, regwr, pc_en, go to FETCH.
  - branch 1100011: imm_sgn=10, pc_en, go to FETCH.
    - beq/bne: SUB; taken = zero / !zero.
    - blt/bge: SLT; taken = !zero / zero.
    - bltu/bgeu: SLTU; taken = !zero / zero.
    - pc_sgn = taken.
  - load 0000011 / store 0100011: ADD with imm (imm_sgn 00 / 01), go to MEM; no commit.
  - Any other opcode: illegal<=1, go to TRAP.
- ALU decode from funct3/funct7[5]: sub and sra are selected by funct7[5] for R-type; srai uses funct7[5] for I-type.
- MEM: dmem_req=1, held until dmem_ack. Address and write data come from the datapath.
  - Store: dmem_we=1 and memwr_sgn=1 while the req is held. On ack: pc_en, go to FETCH.
  - Load: on ack, mdr<=dmem_rdata, go to WB.
- WB: result_sgn=01, regwr (rd!=0), pc_en, go to FETCH.
- TRAP: all req and enable outputs stay 0 until reset.
- Controls are combinational from state+ir; alu_sgn, imm_sgn and alu_main stay stable through MEM/WB.
- regwr_sgn and pc_en are single-cycle pulses, exactly once per retired instruction.
- Acks outside the matching state are ignored.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle out of reset.
  - instret_cnt increments on each pc_en pulse.
  - Both wrap from FFFFFFFF to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants
  - ALU encodings: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
  - imm_sgn and result_sgn encodings
- Sub-module mc_decode: purely combinational ir+zero -> control word and class (alu/mem_ld/mem_st/commit/illegal). The FSM stays in mc_controller.

Test Plan:
- Reset held, then released with RESET_WAIT=2 -> 2 IDLE cycles, then imem_req=1; all enables 0 during reset.
- addi x1,x0,5 (00500093), ack on the req cycle -> EXEC next cycle with alu_sgn=1, alu_main=0000, regwr_sgn=1, pc_en=1; next cycle is FETCH.
- lw x2,0(x1) with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; mdr=dmem_rdata; WB has result_sgn=01, regwr=1, pc_en=1.
- sw with dmem_ack delayed 2 cycles -> memwr_sgn=1 and dmem_we=1 for 3 cycles; pc_en pulses once on ack; regwr_sgn never 1.
- bne with zero=0 -> pc_sgn=1, alu_main=0001, pc_en=1; with zero=1 -> pc_sgn=0.
- Opcode 7'b1111111 -> illegal=1 and stays 1, no further imem_req. Reset asserted mid-MEM -> dmem_req drops immediately and illegal clears.
